// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits LSB first, odd parity,
// stop, then device ack sample. Open-drain enables are registered; rx_inhibit mirrors tx_busy.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,   // must be >= 2
    parameter int unsigned TIMEOUT_CYCLES = 750000  // must be >= 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic       rx_inhibit
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_DAT  = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        DATA,
        ACK,
        WAIT_IDLE
    } state_e;

    state_e           state_q;
    logic [2:0]       clk_sync_q;
    logic [2:0]       dat_sync_q;
    logic [7:0]       data_q;
    logic             parity_q;
    logic [3:0]       bit_cnt_q;
    logic [INH_W-1:0] inh_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             clk_oe_q;
    logic             dat_oe_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic parity_d;
    logic clk_fall;
    logic tmo_hit;

    assign parity_d = ~^tx_data;
    assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];
    // A device edge in the expiry cycle keeps the transfer alive.
    assign tmo_hit  = (tmo_cnt_q == TMO_LAST) & ~clk_fall;

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_err     = err_q;
    assign rx_inhibit = busy_q;

    // Three-flop synchronisers; idle bus level is high.
    always_ff @(posedge clk) begin
        if (clr) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 3'b111;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[1:0], ps2_dat_in};
        end
    end

    // Transfer FSM with registered line enables and status pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            data_q    <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            tmo_cnt_q <= '0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            if (state_q inside {START, DATA, ACK, WAIT_IDLE}) begin
                tmo_cnt_q <= clk_fall ? '0 : tmo_cnt_q + TMO_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (tx_start) begin
                        data_q    <= tx_data;
                        parity_q  <= parity_d;
                        busy_q    <= 1'b1;
                        clk_oe_q  <= 1'b1;
                        inh_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        tmo_cnt_q <= '0;
                        state_q   <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    inh_cnt_q <= inh_cnt_q + INH_W'(1);
                    if (inh_cnt_q == INH_DAT) begin
                        dat_oe_q <= 1'b1;
                    end
                    if (inh_cnt_q == INH_LAST) begin
                        clk_oe_q  <= 1'b0;
                        inh_cnt_q <= '0;
                        tmo_cnt_q <= '0;
                        state_q   <= START;
                    end
                end

                START: begin
                    if (clk_fall) begin
                        dat_oe_q  <= ~data_q[0];
                        bit_cnt_q <= 4'd1;
                        state_q   <= DATA;
                    end else if (tmo_hit) begin
                        state_q   <= IDLE;
                        clk_oe_q  <= 1'b0;
                        dat_oe_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        bit_cnt_q <= '0;
                        tmo_cnt_q <= '0;
                    end
                end

                DATA: begin
                    // Edges 2..8 drive data bits 1..7, edge 9 parity, edge 10 the stop bit.
                    if (clk_fall) begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8) begin
                            dat_oe_q <= ~data_q[bit_cnt_q[2:0]];
                        end else if (bit_cnt_q == 4'd8) begin
                            dat_oe_q <= ~parity_q;
                        end else begin
                            dat_oe_q <= 1'b0;
                            state_q  <= ACK;
                        end
                    end else if (tmo_hit) begin
                        state_q   <= IDLE;
                        clk_oe_q  <= 1'b0;
                        dat_oe_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        bit_cnt_q <= '0;
                        tmo_cnt_q <= '0;
                    end
                end

                ACK: begin
                    if (clk_fall) begin
                        bit_cnt_q <= 4'd11;
                        if (dat_sync_q[2]) begin
                            state_q   <= IDLE;
                            clk_oe_q  <= 1'b0;
                            dat_oe_q  <= 1'b0;
                            busy_q    <= 1'b0;
                            err_q     <= 1'b1;
                            bit_cnt_q <= '0;
                            tmo_cnt_q <= '0;
                        end else begin
                            state_q <= WAIT_IDLE;
                        end
                    end else if (tmo_hit) begin
                        state_q   <= IDLE;
                        clk_oe_q  <= 1'b0;
                        dat_oe_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        bit_cnt_q <= '0;
                        tmo_cnt_q <= '0;
                    end
                end

                WAIT_IDLE: begin
                    if (clk_sync_q[2] & dat_sync_q[2]) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        tmo_cnt_q <= '0;
                    end else if (tmo_hit) begin
                        state_q   <= IDLE;
                        clk_oe_q  <= 1'b0;
                        dat_oe_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        bit_cnt_q <= '0;
                        tmo_cnt_q <= '0;
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host; a monitor
// pops expected results from a scoreboard queue on every tx_done/tx_err pulse.
module tb_ps2_host_tx;

    localparam int unsigned INH    = 50;
    localparam int unsigned TMO    = 400;
    localparam int unsigned H      = 20;
    localparam int unsigned BUDGET = 2000;

    typedef struct packed {
        logic        is_err;
        logic        chk_frame;
        logic [10:0] frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       tx_busy, tx_done, tx_err, rx_inhibit;
    logic       ps2_clk, ps2_dat;

    logic        dev_clk_low, dev_dat_low, dev_ack_high, dev_silent, dev_busy;
    logic [10:0] dev_frame;
    logic        saw_inh;

    int   n_vec  = 0;
    int   n_bad  = 0;
    int   n_done = 0;
    logic prev_busy = 1'b0;
    exp_t exp_q[$];
    exp_t e_mon;

    always #5 clk = ~clk;

    assign ps2_clk = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .ps2_clk_in (ps2_clk),
        .ps2_dat_in (ps2_dat),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .rx_inhibit (rx_inhibit)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic par, input logic is_err, input logic chk);
        exp_t e;
        e.is_err    = is_err;
        e.chk_frame = chk;
        e.frame     = {1'b1, par, d, 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("accept_busy", 32'(tx_busy), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (tx_busy && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (tx_busy) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
        end
    endtask

    task automatic wait_dev();
        int n = 0;
        while (dev_busy && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (dev_busy) begin
            n_vec++;
            n_bad++;
            $display("FAIL device_idle: device model busy after %0d cycles, expected idle", n);
        end
        repeat (5) @(negedge clk);
    endtask

    // Device: clock high half, sample line, clock low half; ack driven before edge 11.
    task automatic run_frame();
        dev_busy  = 1'b1;
        dev_frame = '1;
        for (int i = 0; i < 11; i++) begin
            repeat (H / 2) @(negedge clk);
            dev_frame[i] = ps2_dat;
            if (i == 10) dev_dat_low = ~dev_ack_high;
            repeat (H / 2) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        repeat (H) @(negedge clk);
        dev_dat_low = 1'b0;
        dev_busy    = 1'b0;
    endtask

    initial begin
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        dev_busy    = 1'b0;
        dev_frame   = '1;
        saw_inh     = 1'b0;
        forever begin
            @(negedge clk);
            if (ps2_clk_oe) begin
                saw_inh = 1'b1;
            end else begin
                if (saw_inh && ps2_dat_oe && !dev_silent) run_frame();
                saw_inh = 1'b0;
            end
        end
    end

    // Monitor: every result pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (tx_done || tx_err) begin
            if (tx_done) n_done++;
            check("done_err_exclusive", 32'(tx_done & tx_err), 32'd0);
            check("busy_drop", 32'({tx_busy, rx_inhibit, prev_busy}), 32'd1);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b, expected no pulse", tx_done, tx_err);
            end else begin
                e_mon = exp_q.pop_front();
                check("result_is_err", 32'(tx_err), 32'(e_mon.is_err));
                if (e_mon.chk_frame) check("frame", 32'(dev_frame), 32'(e_mon.frame));
            end
        end
        prev_busy = tx_busy;
    end

    initial begin
        int cnt, first, cyc, falls, n, done0;
        logic prev_clk;
        clr          = 1'b1;
        tx_start     = 1'b0;
        tx_data      = '0;
        dev_ack_high = 1'b0;
        dev_silent   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_busy",   32'(tx_busy),    32'd0);
        check("rst_done",   32'(tx_done),    32'd0);
        check("rst_err",    32'(tx_err),     32'd0);
        check("rst_inhib",  32'(rx_inhibit), 32'd0);
        clr = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED: six ones -> parity 1, device acks.
        done0 = n_done;
        push(8'hED, 1'b1, 1'b0, 1'b1);
        issue(8'hED);
        wait_idle("ed_idle");
        wait_dev();
        check("ed_done_count", 32'(n_done - done0), 32'd1);

        // 0xF4: five ones -> parity 0; measure the inhibit window.
        push(8'hF4, 1'b0, 1'b0, 1'b1);
        issue(8'hF4);
        cnt   = 0;
        first = 0;
        while (ps2_clk_oe && cnt < BUDGET) begin
            cnt++;
            if (ps2_dat_oe && first == 0) first = cnt;
            @(negedge clk);
        end
        check("inhibit_len", 32'(cnt), 32'(INH));
        check("dat_oe_rise", 32'(first), 32'(INH));
        wait_idle("f4_idle");
        wait_dev();

        // 0x55 with no ack from the device.
        dev_ack_high = 1'b1;
        push(8'h55, 1'b1, 1'b1, 1'b1);
        issue(8'h55);
        wait_idle("nack_idle");
        @(negedge clk);
        check("nack_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("nack_dat_oe", 32'(ps2_dat_oe), 32'd0);
        wait_dev();
        dev_ack_high = 1'b0;

        // Silent device: error exactly TMO cycles after clock release, then immediate restart.
        dev_silent = 1'b1;
        push(8'h12, 1'b0, 1'b1, 1'b0);
        issue(8'h12);
        n = 0;
        while (ps2_clk_oe && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        cyc = 0;
        while (!tx_err && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycles", 32'(cyc), 32'(TMO));
        check("tmo_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("tmo_dat_oe", 32'(ps2_dat_oe), 32'd0);
        dev_silent = 1'b0;
        push(8'h01, 1'b0, 1'b0, 1'b1);
        tx_data  = 8'h01;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("restart_busy", 32'(tx_busy), 32'd1);
        wait_idle("restart_idle");
        wait_dev();

        // clr after the 4th device falling edge aborts silently.
        issue(8'h00);
        falls    = 0;
        n        = 0;
        prev_clk = 1'b1;
        while (falls < 4 && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (prev_clk && !ps2_clk) falls++;
            prev_clk = ps2_clk;
        end
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("clr_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("clr_busy",   32'(tx_busy),    32'd0);
        wait_dev();
        push(8'h00, 1'b1, 1'b0, 1'b1);
        issue(8'h00);
        wait_idle("zero_idle");
        wait_dev();

        // Second start while busy is ignored: 0xC7 (five ones -> parity 0) goes out unchanged.
        done0 = n_done;
        push(8'hC7, 1'b0, 1'b0, 1'b1);
        issue(8'hC7);
        repeat (10) @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_idle("c7_idle");
        wait_dev();
        repeat (50) @(negedge clk);
        check("c7_done_count", 32'(n_done - done0), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
